// File: rtl/thresh_ctrl_pkg.sv
// thresh_ctrl_pkg: shared state encodings, fault codes and parameter defaults
// for the threshold_integrator run-control sequencer.
package thresh_ctrl_pkg;
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RELEASE = 3'd1;
   localparam logic [2:0] ARMING  = 3'd2;
   localparam logic [2:0] RUNNING = 3'd3;
   localparam logic [2:0] HALTED  = 3'd4;
   localparam logic [2:0] FAULT_NONE        = 3'd0;
   localparam logic [2:0] FAULT_OVER_THRESH = 3'd1;
   localparam logic [2:0] FAULT_OVERFLOW    = 3'd2;
   localparam logic [2:0] FAULT_UNDERFLOW   = 3'd3;
   localparam logic [2:0] FAULT_TIMEOUT     = 3'd4;
   localparam int unsigned MIN_WINDOW_LOG2_DFLT = 11;
   localparam int unsigned SETUP_TIMEOUT_DFLT   = 4096;
endpackage

// File: rtl/threshold_integrator_ctrl.sv
// threshold_integrator_ctrl: config validation, arm/setup supervision and first-fault latch for the integrator.
// Optional THRESH_CTRL_FAULT_TIMESTAMP_EN adds the fault_cycles run-cycle counter output.
module threshold_integrator_ctrl
   import thresh_ctrl_pkg::*;
#(
   parameter int unsigned SETUP_TIMEOUT   = SETUP_TIMEOUT_DFLT,
   parameter int unsigned MIN_WINDOW_LOG2 = MIN_WINDOW_LOG2_DFLT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] cfg_window,
   input  logic [14:0] cfg_threshold,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   output logic        cfg_reject,
   input  logic        arm,
   input  logic        disarm,
   input  logic        clear_fault,
   output logic        integ_resetn,
   output logic        integ_enable,
   output logic [31:0] integ_window,
   output logic [14:0] integ_threshold,
   input  logic        integ_setup_done,
   input  logic        integ_over_thresh,
   input  logic        integ_err_overflow,
   input  logic        integ_err_underflow,
   output logic        running,
   output logic        shutdown_req,
   output logic [2:0]  fault_code,
   output logic [2:0]  state_out
`ifdef THRESH_CTRL_FAULT_TIMESTAMP_EN
   ,
   output logic [31:0] fault_cycles
`endif
);
   logic [2:0]  state_q, state_d, fault_q, fault_d;
   logic        loaded_q, loaded_d, reject_q, reject_d;
   logic        resetn_q, resetn_d, enable_q, enable_d;
   logic [31:0] window_q, window_d, timer_q, timer_d;
   logic [14:0] thresh_q, thresh_d;
   logic        idle, cfg_ok, cfg_take, timed_out, any_fault;

   assign idle      = state_q == IDLE;
   assign cfg_ok    = (cfg_window >> MIN_WINDOW_LOG2) != 32'd0;
   assign cfg_take  = idle && cfg_valid && cfg_ok;
   assign timed_out = (SETUP_TIMEOUT != 0) && (timer_q == 32'(SETUP_TIMEOUT - 1));
   assign any_fault = integ_err_overflow || integ_err_underflow || integ_over_thresh;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // disarm is tested first everywhere so it wins over setup_done and faults
   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      unique case (state_q)
         IDLE:    if (arm && (loaded_q || cfg_take)) state_d = RELEASE;
         RELEASE: state_d = disarm ? IDLE : ARMING;
         ARMING: begin
            if (disarm) state_d = IDLE;
            else if (integ_setup_done) state_d = RUNNING;
            else if (timed_out) begin
               state_d = HALTED;
               fault_d = FAULT_TIMEOUT;
            end
         end
         RUNNING: begin
            if (disarm) state_d = IDLE;
            else if (any_fault) begin
               state_d = HALTED;
               fault_d = integ_err_overflow  ? FAULT_OVERFLOW :
                         integ_err_underflow ? FAULT_UNDERFLOW : FAULT_OVER_THRESH;
            end
         end
         HALTED: begin
            if (clear_fault || disarm) begin
               state_d = IDLE;
               fault_d = FAULT_NONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Integrator controls are registered from the next state so they line up with state_out
   always_comb begin
      loaded_d = loaded_q || cfg_take;
      window_d = cfg_take ? cfg_window : window_q;
      thresh_d = cfg_take ? cfg_threshold : thresh_q;
      reject_d = idle && cfg_valid && !cfg_ok;
      resetn_d = state_d != IDLE;
      enable_d = (state_d == ARMING) || (state_d == RUNNING);
      timer_d  = (state_q == ARMING) ? timer_q + 32'd1 : 32'd0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fault_q  <= FAULT_NONE;
         loaded_q <= 1'b0;
         reject_q <= 1'b0;
         resetn_q <= 1'b0;
         enable_q <= 1'b0;
         window_q <= '0;
         thresh_q <= '0;
         timer_q  <= '0;
      end else begin
         fault_q  <= fault_d;
         loaded_q <= loaded_d;
         reject_q <= reject_d;
         resetn_q <= resetn_d;
         enable_q <= enable_d;
         window_q <= window_d;
         thresh_q <= thresh_d;
         timer_q  <= timer_d;
      end
   end

   assign cfg_ready       = idle;
   assign running         = state_q == RUNNING;
   assign shutdown_req    = state_q == HALTED;
   assign state_out       = state_q;
   assign cfg_reject      = reject_q;
   assign fault_code      = fault_q;
   assign integ_resetn    = resetn_q;
   assign integ_enable    = enable_q;
   assign integ_window    = window_q;
   assign integ_threshold = thresh_q;

`ifdef THRESH_CTRL_FAULT_TIMESTAMP_EN
   logic [31:0] cyc_q, cyc_d;

   always_comb
      cyc_d = (state_q == RELEASE) ? 32'd0 :
              (((state_q == ARMING) || (state_q == RUNNING)) && !(&cyc_q)) ? cyc_q + 32'd1 : cyc_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cyc_q <= '0;
      else         cyc_q <= cyc_d;
   end

   assign fault_cycles = cyc_q;
`endif
endmodule
